// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor.
// Latches two operands and an opcode, then pushes one bit pair per clock
// (LSB first) through a single full-adder or full-subtractor cell. Carry or
// borrow is kept in a flop between bits, and the result is assembled in a
// shift register that fills from the MSB side.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic x, input logic y, input logic cin);
    full_adder = {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

  // Single-bit full subtractor cell (x - y - bin): returns {borrow_out, diff}.
  function automatic logic [1:0] full_subtractor(input logic x, input logic y, input logic bin);
    full_subtractor = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] a_sr_q,      a_sr_d;
  logic [WIDTH-1:0] b_sr_q,      b_sr_d;
  logic [WIDTH-1:0] res_sr_q,    res_sr_d;
  logic             op_q,        op_d;
  logic             cb_q,        cb_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             carry_out_q, carry_out_d;

  logic [1:0] fa_out;
  logic [1:0] fs_out;
  logic       cell_bit;
  logic       cell_cb;

  // Evaluate both cells on the current bit pair; the latched opcode picks one.
  always_comb begin
    fa_out   = full_adder(a_sr_q[0], b_sr_q[0], cb_q);
    fs_out   = full_subtractor(a_sr_q[0], b_sr_q[0], cb_q);
    cell_bit = op_q ? fs_out[0] : fa_out[0];
    cell_cb  = op_q ? fs_out[1] : fa_out[1];
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    res_sr_d    = res_sr_q;
    op_d        = op_q;
    cb_d        = cb_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          op_d    = op;
          cb_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sr_d = {cell_bit, res_sr_q[WIDTH-1:1]};
        cb_d     = cell_cb;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d    = res_sr_d;
          carry_out_d = cell_cb;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything on every edge.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_sr_q    <= '0;
      op_q        <= 1'b0;
      cb_q        <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      res_sr_q    <= res_sr_d;
      op_q        <= op_d;
      cb_q        <= cb_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed bench for serial_add_sub (WIDTH = 8).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, away from the rising edge the DUT uses.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] hold_res = '0;
  logic         hold_co  = 1'b0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation, starting and ending at a falling edge.
  // mode 0: plain; mode 1: stray start pulse in the 3rd RUN cycle;
  // mode 2: rst asserted in the 4th RUN cycle.
  // exp_busy: number of cycles busy stays high; exp_done_j: cycle index of the
  // done pulse (-1 = none), counted from the cycle after the accepting edge.
  task automatic run_op(input string tag, input logic op_v, input logic [W-1:0] a_v,
                        input logic [W-1:0] b_v, input int mode,
                        input logic [W-1:0] exp_res, input logic exp_co,
                        input int exp_busy, input int exp_done_j);
    int ndone;
    ndone = 0;
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    @(posedge clk);
    #1;
    // Operands are latched; scrambling the inputs must not matter.
    start = 1'b0;
    op    = ~op_v;
    a     = ~a_v;
    b     = a_v ^ 8'h3C;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (mode == 2 && j == 4) begin
        hold_res = '0;
        hold_co  = 1'b0;
      end
      if (j == exp_done_j) begin
        hold_res = exp_res;
        hold_co  = exp_co;
      end
      if (done) ndone++;
      check($sformatf("%s busy c%0d", tag, j), busy, (j < exp_busy));
      check($sformatf("%s done c%0d", tag, j), done, (j == exp_done_j));
      check($sformatf("%s result c%0d", tag, j), result, hold_res);
      check($sformatf("%s carry_out c%0d", tag, j), carry_out, hold_co);
      if (mode == 1 && j == 2) begin
        start = 1'b1;
        op    = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
      end
      if (mode == 1 && j == 3) start = 1'b0;
      if (mode == 2 && j == 3) rst = 1'b1;
      if (mode == 2 && j == 4) rst = 1'b0;
    end
    check($sformatf("%s done count", tag), ndone, (exp_done_j < 0) ? 0 : 1);
    check($sformatf("%s final result", tag), result, exp_res);
    check($sformatf("%s final carry_out", tag), carry_out, exp_co);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 8'h00);
    check("reset carry_out", carry_out, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 1'b0);

    run_op("add 5A+3C", 1'b0, 8'h5A, 8'h3C, 0, 8'h96, 1'b0, 8, 8);
    run_op("add FF+01", 1'b0, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 8, 8);
    run_op("sub 10-01", 1'b1, 8'h10, 8'h01, 0, 8'h0F, 1'b0, 8, 8);
    run_op("sub 00-01", 1'b1, 8'h00, 8'h01, 0, 8'hFF, 1'b1, 8, 8);
    run_op("sub 80-80", 1'b1, 8'h80, 8'h80, 0, 8'h00, 1'b0, 8, 8);
    run_op("add 12+34 stray start", 1'b0, 8'h12, 8'h34, 1, 8'h46, 1'b0, 8, 8);
    run_op("add FF+FF rst abort", 1'b0, 8'hFF, 8'hFF, 2, 8'h00, 1'b0, 4, -1);
    run_op("add 01+02", 1'b0, 8'h01, 8'h02, 0, 8'h03, 1'b0, 8, 8);

    // start held high: accepts every 10 cycles, done never back to back.
    ndone = 0;
    start = 1'b1;
    op    = 1'b1;
    a     = 8'h05;
    b     = 8'h07;
    @(posedge clk);
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done) ndone++;
      check($sformatf("hold busy c%0d", j), busy, ((j % 10) < 8));
      check($sformatf("hold done c%0d", j), done, (j == 8 || j == 18));
      if (j >= 8) begin
        check($sformatf("hold result c%0d", j), result, 8'hFE);
        check($sformatf("hold carry_out c%0d", j), carry_out, 1'b1);
      end
    end
    check("hold done count", ndone, 2);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("drain busy", busy, 1'b0);
    check("drain result", result, 8'hFE);
    check("drain carry_out", carry_out, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
